acl_spi_burst_master: RTL

Parametrised SPI master for the ADXL362-class accelerometer. It generates its own SCLK from the system clock and runs single or multi-byte register read/write bursts behind a start/busy/done handshake. Read bytes are streamed out one at a time, and write bytes are pulled in one at a time. It replaces the fixed one-byte and 12-bit-pair access path and sits between the sensor-polling FSM and the Pmod pins.

---
 rtl/acl_spi_burst_master.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/acl_spi_burst_master.sv
// rtl/acl_spi_burst_master.sv - SPI mode-0 burst master for ADXL362-class sensors; optional ACL_SPI_PAIR12_EN 12-bit sample pairing
module acl_spi_burst_master #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [7:0]  addr,
  input  logic [3:0]  len,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        done,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam int CW = $clog2(2 * CLK_DIV) + 1;
  localparam logic [CW-1:0] SETUP_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] RISE_CNT   = CW'(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST   = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CLK_DIV);
  localparam logic [CW-1:0] GAP_LAST   = CW'(2 * CLK_DIV - 1);
  localparam logic [3:0]    MAX_N      = 4'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DATA, S_HOLD, S_GAP
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [3:0]    byte_cnt;
  logic [3:0]    n_lat;
  logic [3:0]    len_clamped;
  logic          rw_lat;
  logic [7:0]    addr_lat;
  logic [7:0]    tx_byte;
  logic [7:0]    cmd_byte;
  logic [6:0]    rx_sr;
  logic          shifting;
  logic          bit_end;
  logic          byte_end;
  logic          rise;
  logic          first_cyc;
  logic          accept;
  logic          rx_last;

  // Next-state decode plus the pin-level outputs, all derived from the current state and counters
  always_comb begin
    state_nx    = state;
    shifting    = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
    bit_end     = shifting && (cnt == BIT_LAST);
    byte_end    = bit_end && (bit_cnt == 3'd7);
    rise        = shifting && (cnt == RISE_CNT);
    first_cyc   = (state == S_DATA) && (bit_cnt == 3'd0) && (cnt == '0);
    done        = (state == S_GAP) && (cnt == GAP_LAST);
    busy        = (state != S_IDLE) && !done;
    accept      = start && !busy;
    rx_last     = rise && (state == S_DATA) && rw_lat && (bit_cnt == 3'd7);
    cs_n        = (state == S_IDLE) || (state == S_GAP);
    sclk        = shifting && (cnt >= RISE_CNT);
    wr_ready    = first_cyc && !rw_lat;
    cmd_byte    = rw_lat ? 8'h0B : 8'h0A;
    len_clamped = (len == 4'd0) ? 4'd1 : ((len > MAX_N) ? MAX_N : len);
    mosi        = 1'b0;

    case (state)
      S_CMD:  mosi = cmd_byte[~bit_cnt];
      S_ADDR: mosi = addr_lat[~bit_cnt];
      S_DATA: if (!rw_lat) mosi = first_cyc ? wr_data[7] : tx_byte[~bit_cnt];
      default: mosi = 1'b0;
    endcase

    case (state)
      S_IDLE:  if (accept) state_nx = S_SETUP;
      S_SETUP: if (cnt == SETUP_LAST) state_nx = S_CMD;
      S_CMD:   if (byte_end) state_nx = S_ADDR;
      S_ADDR:  if (byte_end) state_nx = S_DATA;
      S_DATA:  if (byte_end && (byte_cnt == n_lat - 4'd1)) state_nx = S_HOLD;
      // The first HOLD cycle is the one in which sclk falls for the last time
      S_HOLD:  if (cnt == HOLD_LAST) state_nx = S_GAP;
      // The last GAP cycle is the done cycle and may accept the next start directly
      S_GAP:   if (done) state_nx = accept ? S_SETUP : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register, phase/bit/byte counters, request latching and TX/RX shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 4'd0;
      n_lat    <= 4'd1;
      rw_lat   <= 1'b0;
      addr_lat <= 8'h00;
      tx_byte  <= 8'h00;
      rx_sr    <= 7'h00;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      state <= state_nx;

      if ((state_nx != state) || bit_end || (state == S_IDLE)) cnt <= '0;
      else cnt <= cnt + 1'b1;

      if (accept) begin
        bit_cnt  <= 3'd0;
        byte_cnt <= 4'd0;
        rw_lat   <= rw;
        addr_lat <= addr;
        n_lat    <= len_clamped;
      end else begin
        if (bit_end) bit_cnt <= bit_cnt + 3'd1;
        if (byte_end && (state == S_DATA)) byte_cnt <= byte_cnt + 4'd1;
      end

      if (wr_ready) tx_byte <= wr_data;

      if (rise && (state == S_DATA) && rw_lat) rx_sr <= {rx_sr[5:0], miso};
      if (rx_last) rd_data <= {rx_sr, miso};
      rd_valid <= rx_last;
    end
  end

`ifdef ACL_SPI_PAIR12_EN
  logic       pair_odd;
  logic [7:0] lsb_byte;

  // Even-index bytes hold the low half, odd-index bytes complete a 12-bit sample
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_odd     <= 1'b0;
      lsb_byte     <= 8'h00;
      sample       <= 12'h000;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (accept) begin
        pair_odd <= 1'b0;
      end else if (rx_last) begin
        if (pair_odd) begin
          sample       <= {rx_sr[2:0], miso, lsb_byte};
          sample_valid <= 1'b1;
        end else begin
          lsb_byte <= {rx_sr, miso};
        end
        pair_odd <= ~pair_odd;
      end
    end
  end
`else
  assign sample       = 12'h000;
  assign sample_valid = 1'b0;
`endif

endmodule
